rcc_wrap_monitor: RTL and testbench

//  Downstream consumer of the 4-bit ripple-carry counter (RCC) output q.
//  - Resynchronises q, whose bits settle at different times and can glitch, into the clk domain.
//  - Filters transients and publishes a stable count.
//  - Classifies each count step as increment, wrap (15->0), restart (non-15 ->0) or skip.
//  - Reports wraps, restarts and skips over a valid/ready event port; keeps a wrap counter.

---
 rtl/rcc_wrap_monitor_pkg.sv | 32 +++
 rtl/rcc_sync_filter.sv | 64 ++++++
 rtl/rcc_wrap_monitor.sv | 94 +++++++++
 tb/tb_rcc_wrap_monitor.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rcc_wrap_monitor_pkg.sv
// Shared definitions for the RCC wrap monitor: widths, event codes,
// classifier FSM states and the count-step classification rule.
package rcc_wrap_monitor_pkg;

   localparam int Q_W = 4;

   localparam logic [1:0] EVT_NONE    = 2'd0;
   localparam logic [1:0] EVT_WRAP    = 2'd1;
   localparam logic [1:0] EVT_RESTART = 2'd2;
   localparam logic [1:0] EVT_SKIP    = 2'd3;

   typedef enum logic {
      ACQUIRE = 1'b0,
      TRACK   = 1'b1
   } state_t;

   function automatic logic [1:0] classify(
      input logic [Q_W-1:0] old_q,
      input logic [Q_W-1:0] new_q
   );
      logic [1:0] c;
      c = EVT_SKIP;
      if (old_q == {Q_W{1'b1}} && new_q == '0)
         c = EVT_WRAP;
      else if (new_q == '0)
         c = EVT_RESTART;
      else if (new_q == old_q + Q_W'(1))
         c = EVT_NONE;
      return c;
   endfunction

endpackage

// File: rtl/rcc_sync_filter.sv
// Two-flop resynchroniser for the ripple counter bits followed by a
// run-length filter that publishes a value once it has been seen steadily.
module rcc_sync_filter
   import rcc_wrap_monitor_pkg::*;
#(
   parameter int STABLE_CYCLES = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [Q_W-1:0] q_in,
   output logic [Q_W-1:0] q_stable,
   output logic           stable_upd,
   output logic           settled
);

   logic [Q_W-1:0] r_s1;
   logic [Q_W-1:0] r_s2;
   logic [Q_W-1:0] r_cand;
   logic [Q_W-1:0] r_q_stable;
   logic [3:0]     r_scnt;
   logic           r_upd;
   logic           r_settled;

   logic [3:0]     w_scnt_nxt;
   logic           w_hit;
   logic           w_held;

   always_comb begin
      w_scnt_nxt = '0;
      if (r_s2 == r_cand)
         w_scnt_nxt = (r_scnt == 4'hF) ? r_scnt : r_scnt + 4'd1;
      w_hit  = (w_scnt_nxt == 4'(STABLE_CYCLES - 1));
      w_held = (w_scnt_nxt >= 4'(STABLE_CYCLES - 1));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1       <= '0;
         r_s2       <= '0;
         r_cand     <= '0;
         r_scnt     <= '0;
         r_q_stable <= '0;
         r_upd      <= 1'b0;
         r_settled  <= 1'b0;
      end else begin
         r_s1      <= q_in;
         r_s2      <= r_s1;
         r_cand    <= r_s2;
         r_scnt    <= w_scnt_nxt;
         r_settled <= w_held;
         r_upd     <= 1'b0;
         // r_s2 equals r_cand here except for a single-sample filter
         if (w_hit && r_s2 != r_q_stable) begin
            r_q_stable <= r_s2;
            r_upd      <= 1'b1;
         end
      end
   end

   assign q_stable   = r_q_stable;
   assign stable_upd = r_upd;
   assign settled    = r_settled;

endmodule

// File: rtl/rcc_wrap_monitor.sv
// Consumes the filtered ripple count, classifies each step and reports
// wraps, restarts and skips through a single-entry valid/ready buffer.
module rcc_wrap_monitor
   import rcc_wrap_monitor_pkg::*;
#(
   parameter int STABLE_CYCLES = 2,
   parameter int WRAP_W        = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [Q_W-1:0]    q_in,
   input  logic              evt_ready,
   output logic [Q_W-1:0]    q_stable,
   output logic              stable_upd,
   output logic [WRAP_W-1:0] wrap_count,
   output logic              evt_valid,
   output logic [1:0]        evt_code,
   output logic [Q_W-1:0]    evt_q,
   output logic              evt_overflow
);

   logic [Q_W-1:0]    w_q_stable;
   logic              w_upd;
   logic              w_settled;
   logic [1:0]        w_code;
   logic              w_accept;

   state_t            r_state;
   logic [Q_W-1:0]    r_q_prev;
   logic [WRAP_W-1:0] r_wrap;
   logic              r_valid;
   logic [1:0]        r_code;
   logic [Q_W-1:0]    r_q;
   logic              r_ovf;

   rcc_sync_filter #(
      .STABLE_CYCLES(STABLE_CYCLES)
   ) u_filter (
      .clk       (clk),
      .reset     (reset),
      .q_in      (q_in),
      .q_stable  (w_q_stable),
      .stable_upd(w_upd),
      .settled   (w_settled)
   );

   always_comb begin
      w_code = EVT_NONE;
      if (r_state == TRACK && w_upd)
         w_code = classify(r_q_prev, w_q_stable);
      w_accept = r_valid & evt_ready;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ACQUIRE;
         r_q_prev <= '0;
         r_wrap   <= '0;
         r_valid  <= 1'b0;
         r_code   <= EVT_NONE;
         r_q      <= '0;
         r_ovf    <= 1'b0;
      end else begin
         // one cycle behind q_stable: the old value on an update cycle
         r_q_prev <= w_q_stable;
         unique case (r_state)
            ACQUIRE: if (w_upd || w_settled) r_state <= TRACK;
            TRACK:   r_state <= TRACK;
         endcase
         if (w_code == EVT_WRAP)
            r_wrap <= r_wrap + WRAP_W'(1);
         if (w_code != EVT_NONE) begin
            if (!r_valid || w_accept) begin
               r_valid <= 1'b1;
               r_code  <= w_code;
               r_q     <= w_q_stable;
            end else begin
               r_ovf <= 1'b1;
            end
         end else if (w_accept) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign q_stable     = w_q_stable;
   assign stable_upd   = w_upd;
   assign wrap_count   = r_wrap;
   assign evt_valid    = r_valid;
   assign evt_code     = r_code;
   assign evt_q        = r_q;
   assign evt_overflow = r_ovf;

endmodule

// File: tb/tb_rcc_wrap_monitor.sv
// Directed plus randomized bench for rcc_wrap_monitor, checked every cycle
// against a sample-window reference model of the monitor's behaviour.
module tb_rcc_wrap_monitor;

   localparam int S  = 2;
   localparam int WW = 8;

   logic          clk;
   logic          reset;
   logic [3:0]    q_in;
   logic          evt_ready;
   logic [3:0]    q_stable;
   logic          stable_upd;
   logic [WW-1:0] wrap_count;
   logic          evt_valid;
   logic [1:0]    evt_code;
   logic [3:0]    evt_q;
   logic          evt_overflow;

   rcc_wrap_monitor #(
      .STABLE_CYCLES(S),
      .WRAP_W       (WW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .q_in        (q_in),
      .evt_ready   (evt_ready),
      .q_stable    (q_stable),
      .stable_upd  (stable_upd),
      .wrap_count  (wrap_count),
      .evt_valid   (evt_valid),
      .evt_code    (evt_code),
      .evt_q       (evt_q),
      .evt_overflow(evt_overflow)
   );

   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   int vectors     = 0;
   int miscompares = 0;

   // reference model state (values visible after each rising edge)
   int      hist[$];
   int      m_stable, m_old, m_wrap, m_code, m_q;
   bit      m_upd, m_track, m_settled, m_valid, m_ovf;

   // bookkeeping for directed checks
   int upd_seen, acc_seen, wraps_seen, wrap_q, last_code, last_q;

   task automatic m_clear();
      hist.delete();
      for (int i = 0; i < S + 1; i++) hist.push_back(0);
      m_stable = 0; m_old = 0; m_wrap = 0; m_code = 0; m_q = 0;
      m_upd = 0; m_track = 0; m_settled = 0; m_valid = 0; m_ovf = 0;
   endtask

   task automatic m_step();
      bit acc, eq;
      int nc, v;
      acc = m_valid && evt_ready;
      nc = 0;
      if (m_track && m_upd) begin
         if (m_old == 15 && m_stable == 0)       nc = 1;
         else if (m_stable == 0)                 nc = 2;
         else if (m_stable == (m_old + 1) % 16)  nc = 0;
         else                                    nc = 3;
      end
      if (nc == 1) m_wrap = (m_wrap + 1) % (1 << WW);
      if (nc != 0) begin
         if (!m_valid || acc) begin
            m_valid = 1; m_code = nc; m_q = m_stable;
         end else begin
            m_ovf = 1;
         end
      end else if (acc) begin
         m_valid = 0;
      end
      m_track = m_track || m_settled || m_upd;
      // accept once the last S synchronised samples agree
      v  = hist[S - 1];
      eq = 1;
      for (int k = 0; k < S; k++) if (hist[k] != v) eq = 0;
      m_settled = eq;
      m_upd = 0;
      if (eq && v != m_stable) begin
         m_old = m_stable; m_stable = v; m_upd = 1;
      end
      hist.push_back(int'(q_in));
      void'(hist.pop_front());
   endtask

   initial m_clear();

   always @(posedge clk or posedge reset) begin
      if (reset) m_clear();
      else       m_step();
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("q_stable",     32'(q_stable),     32'(m_stable));
      chk("stable_upd",   32'(stable_upd),   32'(m_upd));
      chk("wrap_count",   32'(wrap_count),   32'(m_wrap));
      chk("evt_valid",    32'(evt_valid),    32'(m_valid));
      chk("evt_code",     32'(evt_code),     32'(m_code));
      chk("evt_q",        32'(evt_q),        32'(m_q));
      chk("evt_overflow", 32'(evt_overflow), 32'(m_ovf));
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         check_model();
         if (stable_upd) upd_seen++;
         if (evt_valid) begin
            last_code = int'(evt_code);
            last_q    = int'(evt_q);
            if (evt_ready) begin
               acc_seen++;
               if (evt_code == 2'd1) begin
                  wraps_seen++;
                  wrap_q = int'(evt_q);
               end
            end
         end
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_q_stable"}, 32'(q_stable),     0);
      chk({tag, "_upd"},      32'(stable_upd),   0);
      chk({tag, "_wrap"},     32'(wrap_count),   0);
      chk({tag, "_valid"},    32'(evt_valid),    0);
      chk({tag, "_code"},     32'(evt_code),     0);
      chk({tag, "_evt_q"},    32'(evt_q),        0);
      chk({tag, "_ovf"},      32'(evt_overflow), 0);
   endtask

   initial begin
      int cur, nv, hold, upd0, acc0;
      upd_seen = 0; acc_seen = 0; wraps_seen = 0;
      wrap_q = -1; last_code = 0; last_q = 0;

      // 1. reset and silent acquisition
      reset = 1'b1; q_in = 4'd0; evt_ready = 1'b1;
      #14;
      chk_all_zero("rst");
      #1 reset = 1'b0;
      cyc(4);
      chk("acq_no_evt", 32'(evt_valid), 0);

      // 2. full count with one wrap; 4-cycle lag per step
      for (int i = 1; i <= 16; i++) begin
         q_in = 4'(i % 16);
         cyc(3);
         chk("lag_pre", 32'(q_stable), 32'((i - 1) % 16));
         cyc(1);
         chk("lag_hit", 32'(q_stable), 32'(i % 16));
         cyc(1);
      end
      chk("wrap_events", 32'(wraps_seen), 1);
      chk("wrap_evt_q",  32'(wrap_q),     0);
      chk("wrap_cnt1",   32'(wrap_count), 1);

      // 3. single-cycle glitch is filtered out
      q_in = 4'd6;
      cyc(8);
      upd0 = upd_seen; acc0 = acc_seen;
      q_in = 4'd4;
      cyc(1);
      q_in = 4'd6;
      cyc(8);
      chk("glitch_upd", 32'(upd_seen),  32'(upd0));
      chk("glitch_evt", 32'(acc_seen),  32'(acc0));
      chk("glitch_q",   32'(q_stable),  6);

      // 4. restart then skip
      q_in = 4'd9; cyc(8);
      q_in = 4'd0; cyc(8);
      chk("restart_code", 32'(last_code),  2);
      chk("restart_q",    32'(last_q),     0);
      chk("restart_wrap", 32'(wrap_count), 1);
      q_in = 4'd3; cyc(8);
      chk("skip_code", 32'(last_code), 3);
      chk("skip_q",    32'(last_q),    3);

      // 5. back-pressure: first wrap held, later events dropped
      q_in = 4'd15; cyc(8);
      evt_ready = 1'b0;
      q_in = 4'd0;  cyc(8);
      q_in = 4'd15; cyc(8);
      q_in = 4'd0;  cyc(8);
      chk("bp_valid", 32'(evt_valid),    1);
      chk("bp_code",  32'(evt_code),     1);
      chk("bp_q",     32'(evt_q),        0);
      chk("bp_ovf",   32'(evt_overflow), 1);
      chk("bp_wrap",  32'(wrap_count),   3);
      evt_ready = 1'b1;
      cyc(2);
      chk("bp_drain", 32'(evt_valid),    0);
      chk("bp_ovf_sticky", 32'(evt_overflow), 1);

      // 6. reset mid-operation with an event pending
      evt_ready = 1'b0;
      q_in = 4'd5; cyc(8);
      chk("pre_rst_valid", 32'(evt_valid), 1);
      #2 reset = 1'b1; q_in = 4'd0;
      #1 chk_all_zero("mid_rst");
      @(negedge clk);
      reset = 1'b0;
      cyc(4);
      chk("post_rst_no_evt", 32'(evt_valid), 0);
      q_in = 4'd1; cyc(6);
      chk("post_rst_q",   32'(q_stable),  1);
      chk("post_rst_evt", 32'(evt_valid), 0);

      // randomized segments, mostly counting upward
      cur = 1;
      for (int seg = 0; seg < 150; seg++) begin
         nv = ($urandom_range(0, 2) != 0) ? (cur + 1) % 16
                                          : int'($urandom_range(0, 15));
         hold = ($urandom_range(0, 4) == 0) ? 1 : int'($urandom_range(2, 7));
         q_in = 4'(nv);
         for (int h = 0; h < hold; h++) begin
            evt_ready = 1'($urandom_range(0, 1));
            cyc(1);
         end
         cur = nv;
      end
      evt_ready = 1'b1;
      cyc(10);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
